// File: rtl/rx_intf_pkt_fwd.sv
// rx_intf_pkt_fwd
//   Receive-side bridge between the PHY decoder and the PS RX DMA.
//   Captures one decoded packet (header, payload bytes, FCS status) into an
//   internal byte buffer and forwards it as a 64-bit AXI-Stream burst.
//   Also registers ADC or TX-loopback I/Q samples toward baseband.
//   Configuration is through a write-only AXI-Lite slave.
//
// Optional feature macro: RX_INTF_IRQ_EN
//   When defined, rx_pkt_intr pulses for one cycle after the tlast handshake.
//   When undefined, the port and its logic are absent.
//
// Ports
//   adc_clk, adc_rst                 clock, async active-high reset
//   adc_data/adc_valid               ADC I/Q {ant1, ant0}
//   iq*_from_tx_intf, iq_valid_*     TX loopback I/Q
//   sample0/sample1/sample_strobe    registered sample to baseband
//   pkt_header_*, pkt_rate, pkt_len  packet header from the decoder
//   byte_in*, byte_count             payload bytes
//   fcs_in_strobe, fcs_ok            end of packet and FCS result
//   block_rx_dma_to_ps*              XPU forward/block decision
//   s00_axi_*                        AXI-Lite write channel
//   m00_axis_*                       AXI-Stream master
//   rx_pkt_intr                      packet-forwarded interrupt (optional)

module rx_intf_pkt_fwd #(
  parameter int unsigned C_S00_AXI_DATA_WIDTH   = 32,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH   = 7,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int unsigned IQ_DATA_WIDTH          = 16,
  parameter int unsigned MAX_PKT_BYTES          = 4096
) (
  input  logic                                adc_clk,
  input  logic                                adc_rst,
  input  logic [4*IQ_DATA_WIDTH-1:0]          adc_data,
  input  logic                                adc_valid,
  input  logic [2*IQ_DATA_WIDTH-1:0]          iq0_from_tx_intf,
  input  logic [2*IQ_DATA_WIDTH-1:0]          iq1_from_tx_intf,
  input  logic                                iq_valid_from_tx_intf,
  output logic [2*IQ_DATA_WIDTH-1:0]          sample0,
  output logic [2*IQ_DATA_WIDTH-1:0]          sample1,
  output logic                                sample_strobe,
  input  logic                                pkt_header_valid_strobe,
  input  logic                                pkt_header_valid,
  input  logic [7:0]                          pkt_rate,
  input  logic [15:0]                         pkt_len,
  input  logic                                byte_in_strobe,
  input  logic [7:0]                          byte_in,
  input  logic [15:0]                         byte_count,
  input  logic                                fcs_in_strobe,
  input  logic                                fcs_ok,
  input  logic                                block_rx_dma_to_ps_valid,
  input  logic                                block_rx_dma_to_ps,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready
`ifdef RX_INTF_IRQ_EN
  ,
  output logic                                rx_pkt_intr
`endif
);

  localparam int unsigned AXI_NB  = C_S00_AXI_DATA_WIDTH / 8;
  localparam int unsigned REG_IW  = C_S00_AXI_ADDR_WIDTH - 2;
  localparam int unsigned BPW     = C_M00_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned LANE_W  = $clog2(BPW);
  localparam int unsigned BYTE_AW = $clog2(MAX_PKT_BYTES);
  localparam int unsigned WORD_AW = BYTE_AW - LANE_W;
  localparam int unsigned WCW     = $clog2(MAX_PKT_BYTES / BPW + 2);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECV     = 2'd1,
    ST_WAIT_DEC = 2'd2,
    ST_SEND     = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Sample path: one-cycle registered mux between ADC and TX loopback
  // ---------------------------------------------------------------------------
  logic [C_S00_AXI_DATA_WIDTH-1:0] r_reg3;
  logic [C_S00_AXI_DATA_WIDTH-1:0] r_reg5;
  logic [2*IQ_DATA_WIDTH-1:0]      r_sample0;
  logic [2*IQ_DATA_WIDTH-1:0]      r_sample1;
  logic                            r_sample_strobe;

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      r_sample0       <= '0;
      r_sample1       <= '0;
      r_sample_strobe <= 1'b0;
    end else if (r_reg3[0]) begin
      r_sample0       <= iq0_from_tx_intf;
      r_sample1       <= iq1_from_tx_intf;
      r_sample_strobe <= iq_valid_from_tx_intf;
    end else begin
      r_sample0       <= adc_data[2*IQ_DATA_WIDTH-1:0];
      r_sample1       <= adc_data[4*IQ_DATA_WIDTH-1:2*IQ_DATA_WIDTH];
      r_sample_strobe <= adc_valid;
    end
  end

  assign sample0       = r_sample0;
  assign sample1       = r_sample1;
  assign sample_strobe = r_sample_strobe;

  // ---------------------------------------------------------------------------
  // AXI-Lite write slave: ready pulse, register write, held response
  // ---------------------------------------------------------------------------
  logic              r_awready;
  logic              r_bvalid;
  logic              w_wr_en;
  logic [REG_IW-1:0] w_reg_idx;

  assign w_wr_en   = r_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign w_reg_idx = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_reg3    <= '0;
      r_reg5    <= '0;
    end else begin
      // Self-clearing so the ready pulse lasts exactly one cycle
      r_awready <= s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid & ~r_awready;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
      end else if (s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_wr_en) begin
        for (int b = 0; b < AXI_NB; b++) begin
          if (s00_axi_wstrb[b]) begin
            if (w_reg_idx == REG_IW'(3)) r_reg3[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            if (w_reg_idx == REG_IW'(5)) r_reg5[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_next_state;
  logic   w_hdr_ok;
  logic   w_hdr_latch;
  logic   w_fcs_latch;
  logic   w_last_hs;
  logic   r_tvalid;
  logic   r_tlast;

  assign w_hdr_ok  = pkt_header_valid_strobe & pkt_header_valid;
  assign w_last_hs = r_tvalid & m00_axis_tready & r_tlast;

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_hdr_latch  = 1'b0;
    w_fcs_latch  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hdr_ok) begin
          w_hdr_latch  = 1'b1;
          w_next_state = ST_RECV;
        end
      end
      ST_RECV: begin
        // A fresh valid header restarts capture, even mid-packet
        if (w_hdr_ok) begin
          w_hdr_latch  = 1'b1;
          w_next_state = ST_RECV;
        end else if (fcs_in_strobe) begin
          w_fcs_latch = 1'b1;
          if (r_reg5[1] && !fcs_ok) begin
            w_next_state = ST_IDLE;
          end else if (!r_reg5[0]) begin
            w_next_state = ST_SEND;
          end else begin
            w_next_state = ST_WAIT_DEC;
          end
        end
      end
      ST_WAIT_DEC: begin
        if (r_reg5[0] && block_rx_dma_to_ps_valid) begin
          w_next_state = block_rx_dma_to_ps ? ST_IDLE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_last_hs) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Header latch and packet buffer with per-byte written flags
  // ---------------------------------------------------------------------------
  logic [15:0]              r_pkt_len;
  logic [7:0]               r_pkt_rate;
  logic [15:0]              r_len_cap;
  logic                     r_fcs_ok;
  logic [MAX_PKT_BYTES-1:0] r_bvld;
  logic [7:0]               r_mem [MAX_PKT_BYTES];
  logic                     w_byte_wr;
  logic [BYTE_AW-1:0]       w_byte_idx;

  assign w_byte_idx = byte_count[BYTE_AW-1:0];
  assign w_byte_wr  = (r_state == ST_RECV) & byte_in_strobe & ~w_hdr_latch &
                      (32'(byte_count) < MAX_PKT_BYTES);

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      r_pkt_len  <= '0;
      r_pkt_rate <= '0;
      r_len_cap  <= '0;
      r_fcs_ok   <= 1'b0;
      r_bvld     <= '0;
    end else begin
      if (w_hdr_latch) begin
        r_pkt_len  <= pkt_len;
        r_pkt_rate <= pkt_rate;
        r_len_cap  <= (32'(pkt_len) > MAX_PKT_BYTES) ? 16'(MAX_PKT_BYTES) : pkt_len;
        // Clearing the flags makes every unwritten byte read back as zero
        r_bvld     <= '0;
      end else if (w_byte_wr) begin
        r_bvld[w_byte_idx] <= 1'b1;
      end
      if (w_fcs_latch) begin
        r_fcs_ok <= fcs_ok;
      end
    end
  end

  // Byte storage has no reset; stale content is masked by r_bvld
  always_ff @(posedge adc_clk) begin
    if (w_byte_wr) begin
      r_mem[w_byte_idx] <= byte_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stream output: word 0 is the status header, then payload words
  // ---------------------------------------------------------------------------
  logic [WCW-1:0]                    r_word;
  logic [WCW-1:0]                    w_last_idx;
  logic [WORD_AW-1:0]                w_widx;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] w_word_data;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_tdata;
  logic [BPW-1:0]                    r_tstrb;

  assign w_last_idx = WCW'(({1'b0, r_len_cap} + 17'd7) >> LANE_W);
  assign w_widx     = WORD_AW'(r_word - WCW'(1));

  always_comb begin
    w_word_data = '0;
    if (r_word == '0) begin
      w_word_data = C_M00_AXIS_TDATA_WIDTH'({r_fcs_ok, r_pkt_rate, r_pkt_len});
    end else begin
      for (int k = 0; k < BPW; k++) begin
        if (r_bvld[{w_widx, LANE_W'(k)}]) begin
          w_word_data[8*k +: 8] = r_mem[{w_widx, LANE_W'(k)}];
        end
      end
    end
  end

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
      r_word   <= '0;
    end else if (r_state != ST_SEND) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_word   <= '0;
    end else if (w_last_hs) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if ((!r_tvalid || m00_axis_tready) && (r_word <= w_last_idx)) begin
      // Output slot is free (empty or being consumed): load the next word
      r_tvalid <= 1'b1;
      r_tdata  <= w_word_data;
      r_tstrb  <= '1;
      r_tlast  <= (r_word == w_last_idx);
      r_word   <= r_word + WCW'(1);
    end
  end

  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tstrb  = r_tstrb;
  assign m00_axis_tlast  = r_tlast;

`ifdef RX_INTF_IRQ_EN
  // Interrupt: one-cycle pulse after the final word is accepted
  logic r_intr;

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      r_intr <= 1'b0;
    end else begin
      r_intr <= w_last_hs;
    end
  end

  assign rx_pkt_intr = r_intr;
`endif

  // Register bits with no function, collected to document they are intentional
  logic w_unused;
  assign w_unused = &{1'b0, s00_axi_awaddr[1:0],
                      r_reg3[C_S00_AXI_DATA_WIDTH-1:1],
                      r_reg5[C_S00_AXI_DATA_WIDTH-1:2]};

endmodule

// File: tb/tb_rx_intf_pkt_fwd.sv
// Testbench for rx_intf_pkt_fwd: directed scenarios plus randomized packets,
// checked against a byte-level packet model.

module tb_rx_intf_pkt_fwd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [31:0] iq0 = '0, iq1 = '0;
  logic        iq_valid = 1'b0;
  logic [31:0] sample0, sample1;
  logic        sample_strobe;
  logic        hdr_strobe = 1'b0, hdr_valid = 1'b0;
  logic [7:0]  pkt_rate = '0;
  logic [15:0] pkt_len = '0;
  logic        byte_in_strobe = 1'b0;
  logic [7:0]  byte_in = '0;
  logic [15:0] byte_count = '0;
  logic        fcs_in_strobe = 1'b0, fcs_ok = 1'b0;
  logic        dec_valid = 1'b0, dec_block = 1'b0;
  logic [6:0]  awaddr = '0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready = 1'b0;
  logic        tvalid, tlast;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic        tready = 1'b0;
`ifdef RX_INTF_IRQ_EN
  logic        rx_pkt_intr;
`endif

  always #5 clk = ~clk;

  rx_intf_pkt_fwd dut (
    .adc_clk(clk), .adc_rst(rst),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .iq0_from_tx_intf(iq0), .iq1_from_tx_intf(iq1), .iq_valid_from_tx_intf(iq_valid),
    .sample0(sample0), .sample1(sample1), .sample_strobe(sample_strobe),
    .pkt_header_valid_strobe(hdr_strobe), .pkt_header_valid(hdr_valid),
    .pkt_rate(pkt_rate), .pkt_len(pkt_len),
    .byte_in_strobe(byte_in_strobe), .byte_in(byte_in), .byte_count(byte_count),
    .fcs_in_strobe(fcs_in_strobe), .fcs_ok(fcs_ok),
    .block_rx_dma_to_ps_valid(dec_valid), .block_rx_dma_to_ps(dec_block),
    .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast), .m00_axis_tready(tready)
`ifdef RX_INTF_IRQ_EN
    , .rx_pkt_intr(rx_pkt_intr)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 stalled
  int          tv_cnt = 0;
  logic [64:0] got_q[$];       // {tlast, tdata} of every accepted word
  logic [63:0] exp_q[$];
  logic [7:0]  bm [4096];      // model of the packet buffer
  logic [7:0]  pb [8192];      // payload source bytes

  // Stream monitor
  always @(negedge clk) begin
    if (tvalid) tv_cnt++;
    if (tvalid && tready) got_q.push_back({tlast, tdata});
  end

  // Sink ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tready = 1'b1;
        1: tready = ~tready;
        2: tready = 1'($urandom_range(0, 1));
        default: tready = 1'b0;
      endcase
    end
  end

  task automatic axi_wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    bit bv = 0;
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n_vec++;
    if (!got) begin n_err++; $display("FAIL axi_ready: no awready/wready for addr %h", a); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin bv = 1; break; end
    end
    n_vec++;
    if (!bv || bresp !== 2'b00) begin
      n_err++; $display("FAIL axi_bresp: bvalid %0d bresp %b, required 1 / 00", bv, bresp);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] rate, input logic fok,
                          input int nsend, input int skip_pct, input logic hv);
    @(posedge clk); #1;
    hdr_strobe = 1'b1; hdr_valid = hv; pkt_rate = rate; pkt_len = 16'(len);
    if (hv) for (int i = 0; i < 4096; i++) bm[i] = 8'h00;
    @(posedge clk); #1;
    hdr_strobe = 1'b0; hdr_valid = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      byte_in_strobe = ($urandom_range(0, 99) >= skip_pct);
      byte_in = pb[i];
      byte_count = 16'(i);
      if (byte_in_strobe && hv && i < 4096) bm[i] = pb[i];
      @(posedge clk); #1;
      byte_in_strobe = 1'b0;
    end
    fcs_in_strobe = 1'b1; fcs_ok = fok;
    @(posedge clk); #1;
    fcs_in_strobe = 1'b0; fcs_ok = 1'b0;
  endtask

  task automatic decision(input logic blk);
    @(posedge clk); #1;
    dec_valid = 1'b1; dec_block = blk;
    @(posedge clk); #1;
    dec_valid = 1'b0; dec_block = 1'b0;
  endtask

  // Expected burst: status word, then ceil(min(len,4096)/8) little-endian words
  task automatic build_exp(input int len, input logic [7:0] rate, input logic fok);
    int cap;
    logic [63:0] w;
    cap = (len > 4096) ? 4096 : len;
    exp_q.delete();
    exp_q.push_back({39'b0, fok, rate, 16'(len)});
    for (int n = 0; n < (cap + 7) / 8; n++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = bm[8*n + b];
      exp_q.push_back(w);
    end
  endtask

  task automatic check_burst(input string name, input int base);
    int t = 0;
    logic [64:0] e;
    while (got_q.size() < base + exp_q.size() && t < 20000) begin
      @(posedge clk); t++;
    end
    n_vec++;
    if (got_q.size() < base + exp_q.size()) begin
      n_err++;
      $display("FAIL %s timeout: got %0d words, required %0d", name, got_q.size() - base, exp_q.size());
      return;
    end
    repeat (4) @(posedge clk);
    n_vec++;
    if (got_q.size() != base + exp_q.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d words, required %0d", name, got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = {1'(i == exp_q.size() - 1), exp_q[i]};
      n_vec++;
      if (got_q[base + i] !== e) begin
        n_err++;
        $display("FAIL %s word %0d: got %h, required %h", name, i, got_q[base + i], e);
      end
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int v0 = tv_cnt;
    repeat (cycles) @(posedge clk);
    n_vec++;
    if (tv_cnt != v0) begin
      n_err++; $display("FAIL %s: tvalid seen %0d cycles, required 0", name, tv_cnt - v0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({tvalid, tlast, tdata, tstrb, sample0, sample1, sample_strobe, awready, wready, bvalid} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero outputs, tdata %h sample0 %h", tdata, sample0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({tvalid, sample_strobe, bvalid} !== 3'b000) begin
      n_err++; $display("FAIL after_reset: got %b, required 000", {tvalid, sample_strobe, bvalid});
    end
  endtask

  task automatic test_basic();
    int base = got_q.size();
    for (int i = 0; i < 128; i++) pb[i] = 8'(i);
    send_pkt(128, 8'h0B, 1'b1, 128, 0, 1'b1);
    build_exp(128, 8'h0B, 1'b1);
    check_burst("basic", base);
    if (got_q.size() >= base + 17) begin
      n_vec++;
      if (got_q[base][63:0] !== 64'h0000_0000_010B_0080) begin
        n_err++; $display("FAIL basic_word0: got %h, required 00000000010b0080", got_q[base][63:0]);
      end
      n_vec++;
      if (got_q[base + 1][63:0] !== 64'h0706_0504_0302_0100) begin
        n_err++; $display("FAIL basic_word1: got %h, required 0706050403020100", got_q[base + 1][63:0]);
      end
      n_vec++;
      if (got_q[base + 16][64] !== 1'b1) begin
        n_err++; $display("FAIL basic_tlast16: got %b, required 1", got_q[base + 16][64]);
      end
    end
  endtask

  task automatic test_decision();
    int base;
    axi_wr(7'h14, 32'h1, 4'hF);
    send_pkt(128, 8'h0B, 1'b1, 128, 0, 1'b1);
    check_quiet("dec_wait", 20);
    decision(1'b1);
    check_quiet("dec_block", 20);
    base = got_q.size();
    send_pkt(128, 8'h0B, 1'b1, 128, 0, 1'b1);
    check_quiet("dec_wait2", 10);
    decision(1'b0);
    build_exp(128, 8'h0B, 1'b1);
    check_burst("dec_pass", base);
  endtask

  task automatic test_fcs_drop();
    int base;
    for (int i = 0; i < 64; i++) pb[i] = 8'($urandom);
    axi_wr(7'h14, 32'h2, 4'hF);
    send_pkt(64, 8'h0D, 1'b0, 64, 0, 1'b1);
    check_quiet("fcs_drop", 20);
    axi_wr(7'h14, 32'h0, 4'hF);
    send_pkt(64, 8'h0D, 1'b1, 64, 0, 1'b0);
    check_quiet("hdr_invalid", 20);
    base = got_q.size();
    send_pkt(40, 8'h0F, 1'b0, 40, 0, 1'b1);
    build_exp(40, 8'h0F, 1'b0);
    check_burst("fcs_bad_fwd", base);
    if (got_q.size() > base) begin
      n_vec++;
      if (got_q[base][24] !== 1'b0) begin
        n_err++; $display("FAIL fcs_bit: got %b, required 0", got_q[base][24]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base = got_q.size();
    logic pv = 1'b0;
    logic [64:0] pd = '0;
    for (int i = 0; i < 13; i++) pb[i] = 8'($urandom_range(1, 255));
    rdy_mode = 1;
    send_pkt(13, 8'h08, 1'b1, 13, 0, 1'b1);
    repeat (40) begin
      @(negedge clk);
      if (pv) begin
        n_vec++;
        if ({tvalid, tlast, tdata} !== {1'b1, pd}) begin
          n_err++; $display("FAIL bp_hold: got %h, required %h", {tvalid, tlast, tdata}, {1'b1, pd});
        end
      end
      pv = tvalid && !tready;
      pd = {tlast, tdata};
    end
    build_exp(13, 8'h08, 1'b1);
    check_burst("backpressure", base);
    if (got_q.size() >= base + 3) begin
      n_vec++;
      if (got_q[base + 2][63:40] !== 24'h0) begin
        n_err++; $display("FAIL bp_tail: got %h, required 000000", got_q[base + 2][63:40]);
      end
    end
    rdy_mode = 0;
  endtask

  task automatic sample_check(input string name, input logic lb);
    logic [64:0] e;
    repeat (4) begin
      @(posedge clk); #1;
      adc_data = {$urandom, $urandom}; adc_valid = 1'($urandom_range(0, 1));
      iq0 = $urandom; iq1 = $urandom; iq_valid = 1'($urandom_range(0, 1));
      e = lb ? {iq_valid, iq1, iq0} : {adc_valid, adc_data[63:32], adc_data[31:0]};
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({sample_strobe, sample1, sample0} !== e) begin
        n_err++; $display("FAIL %s: got %h, required %h", name, {sample_strobe, sample1, sample0}, e);
      end
    end
  endtask

  task automatic test_loopback();
    axi_wr(7'h0C, 32'h1, 4'h0);
    sample_check("sample_wstrb0", 1'b0);
    axi_wr(7'h0C, 32'h1, 4'hF);
    sample_check("sample_loop", 1'b1);
    axi_wr(7'h0C, 32'h0, 4'hF);
    sample_check("sample_adc", 1'b0);
  endtask

  task automatic test_boundary();
    int base = got_q.size();
    send_pkt(0, 8'h0A, 1'b1, 0, 0, 1'b1);
    build_exp(0, 8'h0A, 1'b1);
    check_burst("len_zero", base);
    for (int i = 0; i < 4100; i++) pb[i] = 8'($urandom);
    rdy_mode = 2;
    base = got_q.size();
    send_pkt(4100, 8'h0C, 1'b1, 4100, 0, 1'b1);
    build_exp(4100, 8'h0C, 1'b1);
    check_burst("len_over_cap", base);
    rdy_mode = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int len = $urandom_range(0, 300);
      logic fok = 1'($urandom_range(0, 1));
      logic drop = 1'($urandom_range(0, 1));
      logic [7:0] rate = 8'($urandom);
      int base;
      for (int i = 0; i < len; i++) pb[i] = 8'($urandom);
      axi_wr(7'h14, {30'b0, drop, 1'b0}, 4'hF);
      rdy_mode = $urandom_range(0, 2);
      base = got_q.size();
      send_pkt(len, rate, fok, len, 20, 1'b1);
      if (drop && !fok) begin
        check_quiet("rand_drop", 20);
      end else begin
        build_exp(len, rate, fok);
        check_burst("rand_pkt", base);
      end
    end
    rdy_mode = 0;
    axi_wr(7'h14, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen = 0;
    for (int i = 0; i < 128; i++) pb[i] = 8'($urandom);
    rdy_mode = 3;
    send_pkt(128, 8'h0B, 1'b1, 128, 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tvalid) begin seen = 1; break; end
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL mid_tvalid: got 0, required 1"); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (tvalid !== 1'b0) begin n_err++; $display("FAIL mid_reset_tvalid: got %b, required 0", tvalid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    base = got_q.size();
    for (int i = 0; i < 50; i++) pb[i] = 8'($urandom);
    send_pkt(50, 8'h09, 1'b1, 50, 0, 1'b1);
    build_exp(50, 8'h09, 1'b1);
    check_burst("after_mid_reset", base);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decision();
    test_fcs_drop();
    test_backpressure();
    test_loopback();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
